// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID fetch queue: stall-vector bit positions
// used by the ctrl unit and the zero word driven into ID on a bubble.
package if_id_queue_pkg;

    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic [31:0] ZEROWORD = 32'h0000_0000;

    // Increment a queue pointer; the pointer width equals log2(DEPTH),
    // so the natural overflow is the modulo-DEPTH wrap.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int unsigned ptr_w);
        logic [31:0] mask;
        mask     = (32'h1 << ptr_w) - 32'h1;
        ptr_next = (ptr + 32'h1) & mask;
    endfunction

endpackage

// File: rtl/if_id_qmem.sv
// Fetch-queue storage: DEPTH entries of {pc,inst}, one synchronous write
// port and one asynchronous read port. No reset; entry validity is
// tracked entirely by the pointers and count in the parent.
module if_id_qmem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed pair into the tail slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID boundary: a DEPTH-entry fetch queue feeding a registered ID-facing
// output. Decouples fetch rate from decode consumption, with flush,
// backpressure and a same-cycle bypass when the queue is empty so the
// unstalled IF->ID latency stays at one cycle.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + INST_W;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic             push;
    logic             advance;
    logic             pop;
    logic             bypass;
    logic             wr_en;
    logic [ENT_W-1:0] rd_entry;

    logic             stall_unused;

    // Only the IF and ID bits of the ctrl stall vector matter here.
    assign stall_unused = ^stall;

    assign if_ready = (count != CNT_W'(DEPTH));

    // Handshake decode: push, pop and bypass are mutually consistent so
    // an entry is either stored, forwarded straight to ID, or refused.
    always_comb begin
        push      = if_valid & if_ready & ~stall[STALL_IF];
        advance   = ~stall[STALL_ID];
        pop       = advance & (count != '0);
        bypass    = advance & (count == '0) & push;
        wr_en     = push & ~bypass & ~rst & ~flush;
        count_nxt = count + CNT_W'(push & ~bypass) - CNT_W'(pop);
    end

    if_id_qmem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_qmem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata ({if_pc, if_inst}),
        .raddr (head),
        .rdata (rd_entry)
    );

    // Pointer/count bookkeeping and the ID register; rst and flush both
    // empty the queue and insert a bubble, dropping any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            id_valid <= 1'b0;
            id_pc    <= ADDR_W'(ZEROWORD);
            id_inst  <= INST_W'(ZEROWORD);
        end else begin
            if (wr_en) begin
                tail <= PTR_W'(ptr_next(32'(tail), PTR_W));
            end
            if (pop) begin
                head <= PTR_W'(ptr_next(32'(head), PTR_W));
            end
            count <= count_nxt;
            if (advance) begin
                if (pop) begin
                    id_valid <= 1'b1;
                    id_pc    <= rd_entry[ENT_W-1:INST_W];
                    id_inst  <= rd_entry[INST_W-1:0];
                end else if (bypass) begin
                    id_valid <= 1'b1;
                    id_pc    <= if_pc;
                    id_inst  <= if_inst;
                end else begin
                    id_valid <= 1'b0;
                    id_pc    <= ADDR_W'(ZEROWORD);
                    id_inst  <= INST_W'(ZEROWORD);
                end
            end
        end
    end

    assign fill_level = count;

endmodule
